cnn_core: RTL and testbench
===========================

CNN_CORE -- requirements
Module: cnn_core

Interface
REQ-001 Parameter IMAGE_WIDTH, default 16; frame is IMAGE_WIDTH x IMAGE_WIDTH 8-bit unsigned pixels in raster order; legal range 4..256.
REQ-002 iClk  input  1  sole clock; all logic on rising edge.
REQ-003 iRst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 iStart  input  1  one-cycle pulse; arms the core and zeroes frame position counters.
REQ-005 iData  input  8  unsigned pixel, sampled when iValid=1.
REQ-006 iValid  input  1  pixel qualifier; any gap pattern is legal.
REQ-007 oResult  output  8  unsigned convolution result.
REQ-008 oValid  output  1  oResult qualifier; one pulse per result.

Function
REQ-009 Two states: IDLE and RUN; iStart in IDLE -> RUN; iStart in RUN -> stay RUN with row/col counters zeroed; no other transitions except reset.
REQ-010 Pixels are accepted only in RUN with iValid=1; iValid in IDLE is ignored, and the start cycle itself accepts no pixel.
REQ-011 Two line buffers of IMAGE_WIDTH x 8 bits plus a 3x3 window register; write/shift only on accepted pixels.
REQ-012 col counts 0..IMAGE_WIDTH-1 per accepted pixel; wraps to 0 and increments row; row wraps to 0 after IMAGE_WIDTH-1, so frames stream back-to-back in RUN without a new iStart.
REQ-013 Valid-mode convolution only: a result is produced for an accepted pixel at (row,col) with row>=2 and col>=2; (IMAGE_WIDTH-2)^2 results per frame (196 at default), in raster order.
REQ-014 No window spans a row wrap or frame boundary; pixels of the previous frame never contribute to rows 0..1 validity.
REQ-015 Fixed kernel (sharpen), top row first: [0 -1 0; -1 5 -1; 0 -1 0], centred on pixel (row-1,col-1).
REQ-016 Sum computed signed, at least 12 bits (range -1020..1275), no intermediate overflow.
REQ-017 Output mapping: sum<0 -> 0 (see REQ-025); sum>255 -> 255; else sum.
REQ-018 Latency: oValid/oResult asserted exactly 2 clocks after the edge that accepts the completing pixel; fully pipelined, one result per clock at continuous iValid.
REQ-019 oValid is high for exactly one cycle per result; oResult holds its last value when oValid=0.
REQ-020 iValid gaps stall window/line buffers only; in-flight pipeline results still emerge at their fixed latency.

Reset
REQ-021 iRst=1 at a rising edge: state IDLE, row=col=0, window and pipeline valid bits cleared, oValid=0, oResult=0 from the next cycle.
REQ-022 Line buffer contents need not be cleared; REQ-014 guarantees they are never used before being rewritten.
REQ-023 Reset mid-frame aborts the frame: results in flight are discarded; pixels are ignored until a new iStart.
REQ-024 iRst has priority over iStart and iValid in the same cycle.

Configuration
REQ-025 Macro CNN_CORE_RELU_EN: defined -> negative sums clamp to 0 (ReLU); undefined -> output is |sum| saturated to 255; all else identical.

Verification
REQ-026 Reset, iStart, 256 pixels all 0x0A continuous -> 196 results all 0x0A, first oValid 2 clocks after the pixel at (2,2), then one per clock with gaps at row wraps.
REQ-027 Impulse frame, 0xFF at (5,5), else 0 -> result for centre (5,5) 0xFF; centres (4,5),(6,5),(5,4),(5,6) 0x00 with CNN_CORE_RELU_EN, 0xFF without; all others 0x00.
REQ-028 Two frames back-to-back (512 pixels, one iStart), all 0x64 -> 392 results of 0x64, no result at rows 0..1 of frame 2.
REQ-029 Constant 0x80 frame with iValid toggling every other cycle -> 196 results of 0x80, each 2 clocks after its completing pixel.
REQ-030 iRst pulse after row 8 -> oValid 0 next cycle; further pixels without iStart -> no output; new iStart + full frame -> 196 correct results.
REQ-031 iValid pixels before iStart -> no output, counters unaffected.

Source files
------------

// File: rtl/cnn_core.sv
// ============================================================================
//  Module   : cnn_core
//  Brief    : Streaming 3x3 sharpen convolution (valid mode) over square
//             8-bit frames. Optional macro CNN_CORE_RELU_EN selects ReLU
//             output clamping instead of absolute value.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_core #(
  parameter int IMAGE_WIDTH = 16
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic [7:0] iData,
  input  logic       iValid,
  output logic [7:0] oResult,
  output logic       oValid
);

  localparam int              c_CW   = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(IMAGE_WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic              w_accept;
  logic [c_CW-1:0]   r_col;
  logic [c_CW-1:0]   r_row;
  logic [7:0]        r_lineA [IMAGE_WIDTH];
  logic [7:0]        r_lineB [IMAGE_WIDTH];
  logic [7:0]        r_win   [3][3];
  logic              r_winValid;
  logic signed [11:0] w_sum;
  logic signed [11:0] r_sum;
  logic              r_sumValid;
  logic signed [11:0] w_mag;
  logic [7:0]        w_mapped;

  always_ff @(posedge iClk) begin
    if (iRst) r_state <= IDLE;
    else      r_state <= w_stateNext;
  end

  // The start cycle never accepts a pixel, even in RUN.
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    if (iStart) w_stateNext = RUN;
    if (r_state == RUN && iValid && !iStart) w_accept = 1'b1;
  end

  always_ff @(posedge iClk) begin
    if (iRst || iStart) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == c_LAST) begin
        r_col <= '0;
        r_row <= (r_row == c_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // lineA holds row-2, lineB holds row-1 at the current column.
  always_ff @(posedge iClk) begin
    if (!iRst && w_accept) begin
      r_lineA[r_col] <= r_lineB[r_col];
      r_lineB[r_col] <= iData;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          r_win[r][c] <= '0;
      r_winValid <= 1'b0;
    end else begin
      if (w_accept) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= r_lineA[r_col];
        r_win[1][2] <= r_lineB[r_col];
        r_win[2][2] <= iData;
      end
      r_winValid <= w_accept && (r_row >= c_CW'(2)) && (r_col >= c_CW'(2));
    end
  end

  function automatic int kernelCoef(input int r, input int c);
    if (r == 1 && c == 1)      return 5;
    else if ((r == 1) != (c == 1)) return -1;
    else                        return 0;
  endfunction

  always_comb begin
    w_sum = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w_sum = w_sum + 12'(kernelCoef(r, c)) * $signed({4'b0000, r_win[r][c]});
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_sum      <= '0;
      r_sumValid <= 1'b0;
    end else begin
      if (r_winValid) r_sum <= w_sum;
      r_sumValid <= r_winValid;
    end
  end

  always_comb begin
`ifdef CNN_CORE_RELU_EN
    w_mag = (r_sum < 0) ? 12'sd0 : r_sum;
`else
    w_mag = (r_sum < 0) ? -r_sum : r_sum;
`endif
    w_mapped = (w_mag > 12'sd255) ? 8'hFF : w_mag[7:0];
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oValid  <= 1'b0;
      oResult <= '0;
    end else begin
      oValid <= r_sumValid;
      if (r_sumValid) oResult <= w_mapped;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cnn_core.sv
// ============================================================================
//  Module   : tb_cnn_core
//  Brief    : Scoreboard bench for cnn_core (directed frames, reset, gaps).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnn_core;
  localparam int W = 16;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iStart = 1'b0;
  logic       iValid = 1'b0;
  logic [7:0] iData = 8'h00;
  logic [7:0] oResult;
  logic       oValid;

  cnn_core #(.IMAGE_WIDTH(W)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iData(iData),
    .iValid(iValid), .oResult(oResult), .oValid(oValid)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct { int val; int t; } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0, nOut = 0, lastRes = 0;
  int mRow = 0, mCol = 0;
  bit mRun = 1'b0;
  int img [W][W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int expVal(input int r, input int c);
    int s;
    s = 5 * img[r-1][c-1] - img[r-2][c-1] - img[r][c-1] - img[r-1][c-2] - img[r-1][c];
`ifdef CNN_CORE_RELU_EN
    if (s < 0) s = 0;
`else
    if (s < 0) s = -s;
`endif
    if (s > 255) s = 255;
    return s;
  endfunction

  // One clock of stimulus; the model tracks accepted pixels only.
  task automatic drive(input bit v, input logic [7:0] d);
    @(negedge iClk); #1;
    iStart = 1'b0; iValid = v; iData = d;
    if (v && mRun) begin
      img[mRow][mCol] = d;
      if (mRow >= 2 && mCol >= 2) q.push_back('{expVal(mRow, mCol), cyc + 3});
      if (mCol == W - 1) begin
        mCol = 0;
        mRow = (mRow == W - 1) ? 0 : mRow + 1;
      end else mCol++;
    end
  endtask

  task automatic startFrame();
    @(negedge iClk); #1;
    iStart = 1'b1; iValid = 1'b1; iData = 8'hEE;
    mRun = 1'b1; mRow = 0; mCol = 0; nOut = 0;
  endtask

  task automatic doReset();
    @(negedge iClk); #1;
    iRst = 1'b1; iStart = 1'b0; iValid = 1'b0;
    q.delete(); mRun = 1'b0; mRow = 0; mCol = 0; lastRes = 0;
    @(negedge iClk);
    check("rstValid", oValid, 0);
    check("rstResult", oResult, 0);
    #1 iRst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  task automatic drainCount(input string tag, input int n);
    idle(6);
    check("queueEmpty", q.size(), 0);
    check(tag, nOut, n);
  endtask

  always @(negedge iClk) begin
    exp_t e;
    if (q.size() > 0 && q[0].t < cyc) begin
      check("missing", cyc, q[0].t);
      void'(q.pop_front());
    end
    if (oValid === 1'b1) begin
      nOut++;
      if (q.size() == 0) check("unexpected", oValid, 0);
      else begin
        e = q.pop_front();
        check("result", oResult, e.val);
        check("latency", cyc, e.t);
        lastRes = e.val;
      end
    end else begin
      check("hold", oResult, lastRes);
    end
  end

  initial begin
    doReset();

    // Pixels before any iStart are ignored.
    nOut = 0;
    repeat (20) drive(1'b1, 8'h33);
    drainCount("preStartCount", 0);

    startFrame();
    repeat (W * W) drive(1'b1, 8'h0A);
    drainCount("constCount", 196);

    startFrame();
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        drive(1'b1, (r == 5 && c == 5) ? 8'hFF : 8'h00);
    drainCount("impulseCount", 196);

    startFrame();
    repeat (2 * W * W) drive(1'b1, 8'h64);
    drainCount("twoFrameCount", 392);

    startFrame();
    repeat (W * W) begin
      drive(1'b1, 8'h80);
      drive(1'b0, 8'h00);
    end
    drainCount("gapCount", 196);

    startFrame();
    repeat (9 * W) drive(1'b1, 8'($urandom_range(0, 255)));
    doReset();
    nOut = 0;
    repeat (40) drive(1'b1, 8'($urandom_range(0, 255)));
    drainCount("afterRstCount", 0);
    startFrame();
    repeat (W * W) drive(1'b1, 8'($urandom_range(0, 255)));
    drainCount("randomCount", 196);

    // Restart mid-frame: 100 pixels then a fresh frame.
    startFrame();
    repeat (100) drive(1'b1, 8'($urandom_range(0, 255)));
    mRun = 1'b1;
    @(negedge iClk); #1;
    iStart = 1'b1; iValid = 1'b1; iData = 8'h11; mRow = 0; mCol = 0;
    repeat (W * W) drive(1'b1, 8'($urandom_range(0, 255)));
    drainCount("restartCount", 254);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
